// File: rtl/jt89_pkg.sv
// Shared constants for the JT89 noise channel: rate encoding, reference tap masks
// and the 2 dB/step attenuation table.
package jt89_pkg;

    typedef enum logic [1:0] {
        RATE_DIV0  = 2'd0,
        RATE_DIV1  = 2'd1,
        RATE_DIV2  = 2'd2,
        RATE_TONE2 = 2'd3
    } rate_e;

    localparam logic [15:0] TAPS_SN76489 = 16'h0009;
    localparam logic [14:0] TAPS_SN94624 = 15'h0003;

    // Table is defined for a 9-bit sample; other widths scale by 2^(sw-9), truncated.
    function automatic logic [31:0] vol_tab(input logic [3:0] vol, input int sw);
        logic [31:0] base;
        case (vol)
            4'd0:    base = 32'd511;
            4'd1:    base = 32'd406;
            4'd2:    base = 32'd322;
            4'd3:    base = 32'd256;
            4'd4:    base = 32'd203;
            4'd5:    base = 32'd161;
            4'd6:    base = 32'd128;
            4'd7:    base = 32'd102;
            4'd8:    base = 32'd81;
            4'd9:    base = 32'd64;
            4'd10:   base = 32'd51;
            4'd11:   base = 32'd40;
            4'd12:   base = 32'd32;
            4'd13:   base = 32'd26;
            4'd14:   base = 32'd20;
            default: base = 32'd0;
        endcase
        if (sw >= 9) return base << (sw - 9);
        return base >> (9 - sw);
    endfunction

endpackage

// File: rtl/jt89_noise_lfsr.sv
// Noise shift register: white/periodic feedback, lock-up guard and reseed on clr.
module jt89_noise_lfsr
    import jt89_pkg::*;
#(
    parameter int            LW   = 16,
    parameter logic [LW-1:0] TAPS = LW'(TAPS_SN76489)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          clr,
    input  logic          step,
    input  logic          white,
    output logic [LW-1:0] shift
);

    localparam logic [LW-1:0] SEED = {1'b1, {(LW-1){1'b0}}};

    logic          fb;
    logic [LW-1:0] shift_nx;

    always_comb begin
        fb       = white ? ^(shift & TAPS) : shift[0];
        // An all-zero register would never leave zero under white feedback.
        shift_nx = (shift == '0) ? SEED : {fb, shift[LW-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= SEED;
        end else if (clr) begin
            shift <= SEED;
        end else if (clk_en && step) begin
            shift <= shift_nx;
        end
    end

endmodule

// File: rtl/jt89_noise_gen.sv
// JT89 noise channel: rate divider / tone-2 follow, LFSR and registered attenuator.
// Optional JT89_NOISE_DBG_EN exposes dbg_shift and dbg_step.
module jt89_noise_gen
    import jt89_pkg::*;
#(
    parameter int            LW   = 16,
    parameter logic [LW-1:0] TAPS = LW'(TAPS_SN76489),
    parameter int            DIV0 = 16,
    parameter int            DIV1 = 32,
    parameter int            DIV2 = 64,
    parameter int            SW   = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          clr,
    input  logic [2:0]    ctrl3,
    input  logic          tone2_tick,
    input  logic [3:0]    vol,
    output logic          bit_out,
    output logic [SW-1:0] snd
`ifdef JT89_NOISE_DBG_EN
    ,
    output logic [LW-1:0] dbg_shift,
    output logic          dbg_step
`endif
);

    localparam int DIV01   = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int DIV_MAX = (DIV01 > DIV2) ? DIV01 : DIV2;
    localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    rate_e         rate;
    logic          white;
    logic [CW-1:0] cnt;
    logic [CW-1:0] reload;
    logic          step;
    logic [LW-1:0] shift;

    assign rate  = rate_e'(ctrl3[1:0]);
    assign white = ctrl3[2];

    always_comb begin
        reload = '0;
        if (rate == RATE_DIV0)      reload = CW'(DIV0 - 1);
        else if (rate == RATE_DIV1) reload = CW'(DIV1 - 1);
        else if (rate == RATE_DIV2) reload = CW'(DIV2 - 1);
    end

    // Rate is only looked at when cnt reaches zero, so a change never truncates a count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            step <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            step <= 1'b0;
        end else if (clk_en) begin
            if (cnt != '0) begin
                cnt  <= cnt - 1'b1;
                step <= 1'b0;
            end else if (rate == RATE_TONE2) begin
                cnt  <= '0;
                step <= tone2_tick;
            end else begin
                cnt  <= reload;
                step <= 1'b1;
            end
        end
    end

    jt89_noise_lfsr #(
        .LW   (LW),
        .TAPS (TAPS)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .clr    (clr),
        .step   (step),
        .white  (white),
        .shift  (shift)
    );

    assign bit_out = shift[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snd <= '0;
        end else if (clk_en) begin
            snd <= shift[0] ? SW'(vol_tab(vol, SW)) : '0;
        end
    end

`ifdef JT89_NOISE_DBG_EN
    assign dbg_shift = shift;
    assign dbg_step  = step;
`endif

endmodule

// File: tb/tb_jt89_noise_gen.sv
// Self-checking bench for jt89_noise_gen (default 16-bit SN76489 configuration).
`timescale 1ns/1ps
module tb_jt89_noise_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] ctrl3 = 3'b000;
    logic       tone2_tick = 1'b0;
    logic [3:0] vol = 4'd0;
    logic       bit_out;
    logic [8:0] snd;
`ifdef JT89_NOISE_DBG_EN
    logic [15:0] dbg_shift;
    logic        dbg_step;
`endif

    int n_vec = 0;
    int n_bad = 0;
    logic exp_bit_q[$];
    int   exp_snd_q[$];

    localparam int VOL_REF [16] = '{511, 406, 322, 256, 203, 161, 128, 102,
                                    81, 64, 51, 40, 32, 26, 20, 0};

    always #5 clk = ~clk;

    jt89_noise_gen #(
        .LW(16), .TAPS(16'h0009), .DIV0(16), .DIV1(32), .DIV2(64), .SW(9)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .clr        (clr),
        .ctrl3      (ctrl3),
        .tone2_tick (tone2_tick),
        .vol        (vol),
        .bit_out    (bit_out),
        .snd        (snd)
`ifdef JT89_NOISE_DBG_EN
        ,
        .dbg_shift  (dbg_shift),
        .dbg_step   (dbg_step)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] white_next(input logic [15:0] s);
        return {^(s & 16'h0009), s[15:1]};
    endfunction

    // One clock cycle with the given enable; returns #1 after the rising edge.
    task automatic cyc(input logic en);
        clk_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clk_en = 1'b0; clr = 1'b0; tone2_tick = 1'b0; vol = 4'd0; ctrl3 = 3'b000;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_vec++;
        if (bit_out !== 1'b0) begin
            n_bad++; $display("FAIL reset_bit_out got=%b want=0", bit_out);
        end
        n_vec++;
        if (snd !== 9'd0) begin
            n_bad++; $display("FAIL reset_snd got=%0d want=0", snd);
        end
`ifdef JT89_NOISE_DBG_EN
        n_vec++;
        if (dbg_shift !== 16'h8000) begin
            n_bad++; $display("FAIL reset_shift got=%h want=8000", dbg_shift);
        end
`endif
        apply_reset();
        repeat (3) cyc(1'b0);
        n_vec++;
        if (bit_out !== 1'b0 || snd !== 9'd0) begin
            n_bad++; $display("FAIL hold_after_reset got bit=%b snd=%0d want bit=0 snd=0", bit_out, snd);
        end
    endtask

    // First step fires on the first enabled tick out of reset, so shift k lands on tick 2+16(k-1)*...
    task automatic test_periodic(input logic [1:0] rate, input int div);
        int   t1, t2, t3;
        logic prev;
        apply_reset();
        ctrl3 = {1'b0, rate};
        t1 = -1; t2 = -1; t3 = -1;
        prev = bit_out;
        for (int t = 1; t <= 32 * div + 10; t++) begin
            cyc(1'b1);
            if (!prev && bit_out) begin
                if (t1 < 0) t1 = t;
                else if (t3 < 0) t3 = t;
            end
            if (prev && !bit_out && t1 >= 0 && t2 < 0) t2 = t;
            prev = bit_out;
        end
        n_vec++;
        if (t1 !== 2 + 14 * div) begin
            n_bad++; $display("FAIL periodic_first_rise rate=%0d got=%0d want=%0d", rate, t1, 2 + 14 * div);
        end
        n_vec++;
        if (t2 - t1 !== div) begin
            n_bad++; $display("FAIL periodic_high_width rate=%0d got=%0d want=%0d", rate, t2 - t1, div);
        end
        n_vec++;
        if (t3 - t1 !== 16 * div) begin
            n_bad++; $display("FAIL periodic_period rate=%0d got=%0d want=%0d", rate, t3 - t1, 16 * div);
        end
    endtask

    task automatic test_white();
        logic [15:0] s;
        int          k;
        logic        e;
        apply_reset();
        ctrl3 = 3'b100;
        s = 16'h8000;
        k = 0;
        for (int t = 1; t <= 2 + 16 * 39 + 15; t++) begin
            if (t >= 2 && (t - 2) % 16 == 0) begin
                s = white_next(s);
                k++;
                exp_bit_q.push_back(s[0]);
            end else if (t >= 2 && (t - 2) % 16 == 15) begin
                exp_bit_q.push_back(s[0]);
            end
            cyc(1'b1);
            if (exp_bit_q.size() > 0) begin
                e = exp_bit_q.pop_front();
                n_vec++;
                if (bit_out !== e) begin
                    n_bad++; $display("FAIL white_bit tick=%0d shifts=%0d got=%b want=%b", t, k, bit_out, e);
                end
            end
`ifdef JT89_NOISE_DBG_EN
            if (t == 2 + 16 * 11) begin
                n_vec++;
                if (dbg_shift !== 16'h0008) begin
                    n_bad++; $display("FAIL white_state12 got=%h want=0008", dbg_shift);
                end
            end
            if (t == 2 + 16 * 12) begin
                n_vec++;
                if (dbg_shift !== 16'h8004) begin
                    n_bad++; $display("FAIL white_state13 got=%h want=8004", dbg_shift);
                end
            end
`endif
        end
    endtask

    // One clk_en-aligned tone-2 tick at 1/4 duty, optionally with a stray tick while clk_en is low.
    task automatic rate3_pulse(input logic stray);
        tone2_tick = 1'b1; cyc(1'b1);
        tone2_tick = 1'b0; cyc(1'b0);
        tone2_tick = stray; cyc(1'b0);
        tone2_tick = 1'b0; cyc(1'b0);
        cyc(1'b1);
        repeat (3) cyc(1'b0);
    endtask

    task automatic test_rate3();
        logic e;
        apply_reset();
        ctrl3 = 3'b011;
        for (int i = 0; i < 5; i++) rate3_pulse(i < 3);
        exp_bit_q.push_back(1'b0);
        e = exp_bit_q.pop_front();
        n_vec++;
        if (bit_out !== e) begin
            n_bad++; $display("FAIL rate3_after5 got=%b want=%b", bit_out, e);
        end
`ifdef JT89_NOISE_DBG_EN
        n_vec++;
        if (dbg_shift !== 16'h0400) begin
            n_bad++; $display("FAIL rate3_state5 got=%h want=0400", dbg_shift);
        end
`endif
        // The seed's 1 reaches bit 0 on exactly the 15th accepted tick.
        for (int j = 1; j <= 10; j++) begin
            exp_bit_q.push_back(j == 10);
            rate3_pulse(1'b0);
            e = exp_bit_q.pop_front();
            n_vec++;
            if (bit_out !== e) begin
                n_bad++; $display("FAIL rate3_shift shifts=%0d got=%b want=%b", 5 + j, bit_out, e);
            end
        end
    endtask

    task automatic test_clr();
        int t1;
        apply_reset();
        ctrl3 = 3'b000;
        repeat (17) cyc(1'b1);
        clr = 1'b1;
        cyc(1'b1);
        clr = 1'b0;
`ifdef JT89_NOISE_DBG_EN
        n_vec++;
        if (dbg_shift !== 16'h8000 || dbg_step !== 1'b0) begin
            n_bad++; $display("FAIL clr_step_state got shift=%h step=%b want shift=8000 step=0", dbg_shift, dbg_step);
        end
`endif
        t1 = -1;
        for (int t = 1; t <= 300 && t1 < 0; t++) begin
            cyc(1'b1);
            if (bit_out) t1 = t;
        end
        n_vec++;
        if (t1 !== 226) begin
            n_bad++; $display("FAIL clr_step_rise got=%0d want=226", t1);
        end
        clr = 1'b1;
        cyc(1'b0);
        clr = 1'b0;
        n_vec++;
        if (bit_out !== 1'b0) begin
            n_bad++; $display("FAIL clr_no_en got=%b want=0", bit_out);
        end
        t1 = -1;
        for (int t = 1; t <= 300 && t1 < 0; t++) begin
            cyc(1'b1);
            if (bit_out) t1 = t;
        end
        n_vec++;
        if (t1 !== 226) begin
            n_bad++; $display("FAIL clr_no_en_rise got=%0d want=226", t1);
        end
    endtask

    task automatic test_atten();
        int e;
        apply_reset();
        ctrl3 = 3'b000;
        for (int t = 1; t <= 300 && !bit_out; t++) cyc(1'b1);
        n_vec++;
        if (snd !== 9'd0 || bit_out !== 1'b1) begin
            n_bad++; $display("FAIL atten_latency got bit=%b snd=%0d want bit=1 snd=0", bit_out, snd);
        end
        for (int v = 0; v < 16; v++) begin
            vol = 4'(v);
            exp_snd_q.push_back(VOL_REF[v]);
            cyc(1'b1);
            e = exp_snd_q.pop_front();
            n_vec++;
            if (snd !== 9'(e)) begin
                n_bad++; $display("FAIL atten_vol vol=%0d got=%0d want=%0d", v, snd, e);
            end
            if (v == 0) begin
                vol = 4'hF;
                exp_snd_q.push_back(VOL_REF[0]);
                cyc(1'b0);
                e = exp_snd_q.pop_front();
                n_vec++;
                if (snd !== 9'(e)) begin
                    n_bad++; $display("FAIL atten_hold got=%0d want=%0d", snd, e);
                end
            end
        end
        vol = 4'd0;
        exp_snd_q.push_back(0);
        cyc(1'b1);
        e = exp_snd_q.pop_front();
        n_vec++;
        if (bit_out !== 1'b0 || snd !== 9'(e)) begin
            n_bad++; $display("FAIL atten_bit_low got bit=%b snd=%0d want bit=0 snd=%0d", bit_out, snd, e);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        ctrl3 = 3'b000;
        vol = 4'd0;
        for (int t = 1; t <= 300 && !bit_out; t++) cyc(1'b1);
        cyc(1'b1);
        n_vec++;
        if (snd !== 9'd511) begin
            n_bad++; $display("FAIL async_pre got=%0d want=511", snd);
        end
        clk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (snd !== 9'd0 || bit_out !== 1'b0) begin
            n_bad++; $display("FAIL async_reset got bit=%b snd=%0d want bit=0 snd=0", bit_out, snd);
        end
`ifdef JT89_NOISE_DBG_EN
        n_vec++;
        if (dbg_shift !== 16'h8000) begin
            n_bad++; $display("FAIL async_shift got=%h want=8000", dbg_shift);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_periodic(2'd0, 16);
        test_periodic(2'd1, 32);
        test_periodic(2'd2, 64);
        test_white();
        test_rate3();
        test_clr();
        test_atten();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
